// File: rtl/lot_entry_ctrl.sv
// Player-input front end for the lottery core: synchronises and debounces the
// push-buttons, rejects repeated numbers and emits insere/fim/dup_err strobes.

module lot_key_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= key_n;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Only the falling edge of the debounced level is a press.
    assign press = deb_prev_q & ~deb_q;
endmodule

// state   | meaning
// IDLE    | round open, nothing accepted yet
// COLLECT | at least one number accepted, fim press may close
// CLOSE   | round closing, fim strobe issued on exit
// DONE    | round closed, waiting for round_clr
module lot_entry_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int MAX_NUMS   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_insere_n,
    input  logic       key_fim_n,
    input  logic [3:0] sw_num,
    input  logic       round_clr,
    output logic [3:0] num,
    output logic       insere,
    output logic       fim,
    output logic       dup_err,
    output logic [4:0] count,
    output logic [1:0] entry_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CLOSE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [4:0] MAX_CNT = 5'(MAX_NUMS);

    logic        ins_ev;
    logic        fim_ev;
    logic        is_dup;
    logic [4:0]  cnt_d;
    logic        hit_max;

    state_t      state_q;
    logic [15:0] used_q;
    logic [4:0]  cnt_q;
    logic [3:0]  num_q;
    logic        ins_q;
    logic        fim_q;
    logic        dup_q;

    lot_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ins (
        .clk   (clk),
        .reset (reset),
        .key_n (key_insere_n),
        .press (ins_ev)
    );

    lot_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fim (
        .clk   (clk),
        .reset (reset),
        .key_n (key_fim_n),
        .press (fim_ev)
    );

    assign is_dup  = used_q[sw_num];
    assign cnt_d   = cnt_q + 5'd1;
    assign hit_max = (cnt_d == MAX_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            used_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            ins_q   <= 1'b0;
            fim_q   <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            ins_q <= 1'b0;
            fim_q <= 1'b0;
            dup_q <= 1'b0;
            if (round_clr) begin
                used_q  <= '0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_COLLECT: begin
                        // An insert press wins over a simultaneous fim press.
                        if (ins_ev) begin
                            if (is_dup) begin
                                dup_q <= 1'b1;
                            end else if (cnt_q < MAX_CNT) begin
                                num_q          <= sw_num;
                                ins_q          <= 1'b1;
                                used_q[sw_num] <= 1'b1;
                                cnt_q          <= cnt_d;
                                state_q        <= hit_max ? S_CLOSE : S_COLLECT;
                            end
                        end else if (fim_ev && state_q == S_COLLECT && cnt_q != 5'd0) begin
                            state_q <= S_CLOSE;
                        end
                    end
                    S_CLOSE: begin
                        fim_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                endcase
            end
        end
    end

    assign num         = num_q;
    assign insere      = ins_q;
    assign fim         = fim_q;
    assign dup_err     = dup_q;
    assign count       = cnt_q;
    assign entry_state = state_q;
endmodule
